// File: rtl/up_packet_sequencer.sv
// Byte-serial uP bridge: receives a 6-byte command frame over a two-wire handshake, performs one
// register access, then returns an 8-byte reply (data word followed by status word).
module up_packet_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uP_start,
  input  logic        uP_handshake_1,
  input  logic        uP_RW,
  input  logic [7:0]  uP_data_in,
  output logic [7:0]  uP_data_out,
  output logic        uP_data_oe,
  output logic        uP_handshake_2,
  output logic        uP_ack,
  output logic [7:0]  reg_address,
  output logic [31:0] reg_wdata,
  output logic        reg_write,
  output logic        reg_read,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ready
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StIdle, StRxWaitH1, StRxWaitL1, StExecute, StWaitReady,
    StTxPresent, StTxWaitH1, StTxWaitL1, StDone
  } state_t;

  state_t            r_state;
  logic [2:0]        r_count;
  logic [7:0]        r_rx [6];
  logic [31:0]       r_data;
  logic [31:0]       r_status;
  logic [TimerW-1:0] r_timer;
  logic [7:0]        r_dout;
  logic              r_oe;
  logic              r_hs2;
  logic              r_ack;
  logic [7:0]        r_addr;
  logic [31:0]       r_wdata;
  logic              r_write;
  logic              r_read;

  logic [31:0] w_rx_word;
  logic [31:0] w_reply;
  logic        w_abort;

  assign w_rx_word = {r_rx[5], r_rx[4], r_rx[3], r_rx[2]};
  assign w_reply   = (r_rx[0] == 8'd1) ? r_wdata : reg_rdata;
  assign w_abort   = !uP_start && (r_state != StIdle) && (r_state != StDone);

  // Reply bytes: data[7:0] first, status[31:24] last.
  function automatic logic [7:0] tx_byte(input logic [31:0] data, input logic [31:0] status,
                                         input logic [2:0] idx);
    logic [63:0] w_all;
    w_all = {status, data};
    return w_all[{idx, 3'b000} +: 8];
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_count  <= '0;
      for (int i = 0; i < 6; i++) r_rx[i] <= '0;
      r_data   <= '0;
      r_status <= '0;
      r_timer  <= '0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_hs2    <= 1'b0;
      r_ack    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_write  <= 1'b0;
      r_read   <= 1'b0;
    end else begin
      r_write <= 1'b0;
      r_read  <= 1'b0;
      if (w_abort) begin
        r_state <= StIdle;
        r_count <= '0;
        r_dout  <= '0;
        r_oe    <= 1'b0;
        r_hs2   <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        case (r_state)
          StIdle: begin
            if (uP_start) begin
              r_state <= StRxWaitH1;
              r_count <= '0;
            end
          end
          StRxWaitH1: begin
            if (uP_handshake_1 && uP_RW) begin
              r_rx[r_count] <= uP_data_in;
              r_hs2         <= 1'b1;
              r_state       <= StRxWaitL1;
            end
          end
          StRxWaitL1: begin
            if (!uP_handshake_1) begin
              r_hs2 <= 1'b0;
              if (r_count == 3'd5) begin
                r_count <= '0;
                r_state <= StExecute;
              end else begin
                r_count <= r_count + 3'd1;
                r_state <= StRxWaitH1;
              end
            end
          end
          StExecute: begin
            r_status <= {24'b0, r_rx[0]};
            r_timer  <= '0;
            if (r_rx[0] == 8'd1) begin
              r_addr  <= r_rx[1];
              r_wdata <= w_rx_word;
              r_write <= 1'b1;
              r_state <= StWaitReady;
            end else if (r_rx[0] == 8'd0) begin
              r_addr  <= r_rx[1];
              r_read  <= 1'b1;
              r_state <= StWaitReady;
            end else begin
              r_data   <= '0;
              r_status <= {22'b0, 1'b0, 1'b1, r_rx[0]};
              r_dout   <= '0;
              r_oe     <= 1'b1;
              r_state  <= StTxPresent;
            end
          end
          StWaitReady: begin
            // reg_ready is ignored during the strobe cycle itself.
            if (r_write || r_read) begin
              r_timer <= '0;
            end else if (reg_ready) begin
              r_data  <= w_reply;
              r_dout  <= w_reply[7:0];
              r_oe    <= 1'b1;
              r_state <= StTxPresent;
            end else if (r_timer == TimerMax) begin
              r_data    <= '0;
              r_status[9] <= 1'b1;
              r_dout    <= '0;
              r_oe      <= 1'b1;
              r_state   <= StTxPresent;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
          StTxPresent: begin
            // Byte was placed on the bus on entry, so it leads the strobe by a cycle.
            r_hs2   <= 1'b1;
            r_state <= StTxWaitH1;
          end
          StTxWaitH1: begin
            if (uP_handshake_1) begin
              r_hs2   <= 1'b0;
              r_state <= StTxWaitL1;
            end
          end
          StTxWaitL1: begin
            if (!uP_handshake_1) begin
              if (r_count == 3'd7) begin
                r_count <= '0;
                r_dout  <= '0;
                r_oe    <= 1'b0;
                r_ack   <= 1'b1;
                r_state <= StDone;
              end else begin
                r_count <= r_count + 3'd1;
                r_dout  <= tx_byte(r_data, r_status, r_count + 3'd1);
                r_state <= StTxPresent;
              end
            end
          end
          StDone: begin
            if (!uP_start) begin
              r_ack   <= 1'b0;
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign uP_data_out    = r_dout;
  assign uP_data_oe     = r_oe & ~uP_RW;
  assign uP_handshake_2 = r_hs2;
  assign uP_ack         = r_ack;
  assign reg_address    = r_addr;
  assign reg_wdata      = r_wdata;
  assign reg_write      = r_write;
  assign reg_read       = r_read;

endmodule

// File: doc/up_packet_sequencer.md
UP_PACKET_SEQUENCER -- requirements
Module: up_packet_sequencer

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum cycles to wait for reg_ready before aborting the access.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-low reset.
- uP_start  in  1  transaction frame, already synchronised.
- uP_handshake_1  in  1  uP strobe/ack, already synchronised.
- uP_RW  in  1  1 = uP driving the bus, already synchronised.
- uP_data_in  in  8  byte from the uP bus.
- uP_data_out  out  8  byte to the uP bus.
- uP_data_oe  out  1  tri-state enable for uP_data_out.
- uP_handshake_2  out  1  block strobe/ack.
- uP_ack  out  1  transaction complete.
- reg_address  out  8  register address.
- reg_wdata  out  32  register write data.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe.
- reg_rdata  in  32  register read data.
- reg_ready  in  1  access complete.

Function
REQ-003 The FSM SHALL have the states IDLE, RX_WAIT_H1, RX_WAIT_L1, EXECUTE, WAIT_READY, TX_PRESENT, TX_WAIT_H1, TX_WAIT_L1 and DONE.
REQ-004 The block SHALL leave IDLE for RX_WAIT_H1 when uP_start=1; the byte counter SHALL clear to 0.
REQ-005 In RX_WAIT_H1, when uP_handshake_1=1 and uP_RW=1, the block SHALL latch uP_data_in into receive byte[count], set uP_handshake_2=1 on the next edge, and go to RX_WAIT_L1.
REQ-006 In RX_WAIT_L1, when uP_handshake_1=0, the block SHALL clear uP_handshake_2 and increment the count. After byte 5 it SHALL go to EXECUTE; otherwise it SHALL return to RX_WAIT_H1.
REQ-007 Receive byte order SHALL be: command, reg_address, then data[7:0], [15:8], [23:16], [31:24].
REQ-008 In EXECUTE, for command 1 the block SHALL drive reg_address and reg_wdata and pulse reg_write for exactly 1 cycle.
REQ-009 In EXECUTE, for command 0 the block SHALL drive reg_address and pulse reg_read for exactly 1 cycle.
REQ-010 After the strobe, the block SHALL enter WAIT_READY.
REQ-011 reg_ready SHALL be sampled from the cycle after the strobe. When reg_ready=1, the block SHALL latch the reply data and go to TX_PRESENT.
REQ-012 Reply data SHALL be reg_rdata for a read and the written value for a write.
REQ-013 Any command value above 1 SHALL NOT strobe the register bus. The block SHALL go straight to TX_PRESENT with data=0 and status[8]=1.
REQ-014 If reg_ready is absent for TIMEOUT_CYCLES cycles, the block SHALL go to TX_PRESENT with data=0 and status[9]=1.
REQ-015 The status word SHALL be: [7:0] command echo, [8] bad command, [9] timeout, [31:10] zero.
REQ-016 The block SHALL transmit 8 bytes: data[7:0] up to data[31:24], then status[7:0] up to status[31:24].
REQ-017 In TX_PRESENT, the block SHALL drive uP_data_out with byte[count], set uP_data_oe=1 and uP_handshake_2=1, and go to TX_WAIT_H1.
REQ-018 The byte SHALL be stable on uP_data_out for at least 1 cycle before uP_handshake_2 rises.
REQ-019 In TX_WAIT_H1, on uP_handshake_1=1 the block SHALL clear uP_handshake_2 and go to TX_WAIT_L1.
REQ-020 In TX_WAIT_L1, on uP_handshake_1=0 the block SHALL increment the count. After byte 7 it SHALL go to DONE; otherwise it SHALL return to TX_PRESENT.
REQ-021 uP_data_oe SHALL be 1 only from TX_PRESENT through TX_WAIT_L1, and SHALL be 0 whenever uP_RW=1.
REQ-022 In DONE, uP_ack SHALL be 1 and uP_data_oe SHALL be 0. When uP_start=0, the block SHALL clear uP_ack and return to IDLE.
REQ-023 If uP_start falls in any state other than IDLE or DONE, the block SHALL abort to IDLE on the next edge with all strobes and handshakes cleared.
REQ-024 An abort before EXECUTE SHALL produce no register access. An access already strobed SHALL NOT be repeated.
REQ-025 In RX_WAIT_H1, uP_handshake_1=1 with uP_RW=0 SHALL be ignored: no latch and no state change.
REQ-026 reg_write and reg_read SHALL never be 1 in the same cycle.

Reset
REQ-027 While reset=0, the state SHALL be IDLE and the count 0.
REQ-028 While reset=0, uP_handshake_2, uP_ack, uP_data_oe, reg_write and reg_read SHALL be 0.
REQ-029 While reset=0, uP_data_out, reg_address, reg_wdata and the latched data/status SHALL be 0.
REQ-030 Assertion of reset mid-transaction SHALL take effect immediately, independent of clk. The block SHALL restart in IDLE after reset=1.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Write cmd=1, addr=0x10, data=0x12345678, reg_ready 3 cycles after the strobe -> one reg_write pulse with addr 0x10 and wdata 0x12345678; reply data=0x12345678, status=0x00000001; uP_ack=1 until uP_start=0.
- Read cmd=0, addr=0x10, reg_rdata=0x00000064 -> one reg_read pulse; reply data=0x00000064, status=0x00000000.
- cmd=0x07 -> no strobe; data=0, status=0x00000107.
- Read with reg_ready held 0 and TIMEOUT_CYCLES=255 -> TX begins at cycle 256 after the strobe; data=0, status=0x00000200.
- uP_start dropped after byte 3 -> return to IDLE; no strobe; next full write completes correctly.
- reset=0 asserted during TX byte 4 -> all outputs 0 at once; after release, the next read completes correctly.
